// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage.
// Holds the default datapath width, the bubble instruction and the fetch FSM encoding.
// Contents:
//   XLEN           default datapath/address width
//   NOP_INST       bubble instruction (addi x0,x0,0)
//   FETCH_*        fetch state encodings, used by fetch_state_e
package fetch_stage_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [1:0] FETCH_IDLE = 2'd0;  // nothing outstanding
  localparam logic [1:0] FETCH_WAIT = 2'd1;  // one imem request outstanding
  localparam logic [1:0] FETCH_HOLD = 2'd2;  // response parked in the holding buffer

  typedef enum logic [1:0] {
    StIdle = FETCH_IDLE,
    StWait = FETCH_WAIT,
    StHold = FETCH_HOLD
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// Signals:
//   req     request valid (master -> slave)
//   addr    request address (master -> slave)
//   gnt     request accepted this cycle; fire = req & gnt (slave -> master)
//   rvalid  response valid, at least one cycle after fire, in order (slave -> master)
//   rdata   response instruction (slave -> master)
// Modports: master (fetch side), slave (memory side).
interface fetch_stage_if #(
  parameter int unsigned XLEN = fetch_stage_pkg::XLEN
);

  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [31:0]     rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/fetch_stage_resp_buf.sv
// One-entry {pc, inst} holding buffer for an imem response that arrives while IF/ID is stalled.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   load             capture load_pc/load_inst and mark the entry valid (wins over clear)
//   clear            invalidate the entry
//   load_pc          PC of the response being parked
//   load_inst        instruction of the response being parked
//   valid            entry holds a parked response
//   pc, inst         parked PC and instruction
module fetch_stage_resp_buf #(
  parameter int unsigned XLEN     = fetch_stage_pkg::XLEN,
  parameter logic [31:0] NOP_INST = fetch_stage_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_inst,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     inst
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     inst_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= NOP_INST;
    end else if (load) begin
      valid_q <= 1'b1;
      pc_q    <= load_pc;
      inst_q  <= load_inst;
    end else if (clear) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign inst  = inst_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues at most one outstanding imem request and drives the IF/ID
// pipeline register. Tolerates variable-latency imem; a response that arrives while IF/ID is
// stalled is parked in fetch_stage_resp_buf, and a response made stale by a redirect is dropped.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   pc_from_taken     redirect PC to ex_mem_pc_target (mispredict), highest priority
//   pc_stall          do not issue a new fetch this cycle
//   if_id_stall       hold IF/ID contents
//   if_id_flush       load a bubble into IF/ID
//   ex_mem_pc_target  redirect target
//   imem              fetch_stage_if master (req/addr out, gnt/rvalid/rdata in)
//   if_id_valid       IF/ID holds a real instruction
//   if_id_pc          PC of the IF/ID instruction
//   if_id_inst        IF/ID instruction (NOP_INST when bubble)
// Optional feature, macro FETCH_PERF_EN: adds perf_fetch_cnt (instructions delivered to IF/ID),
//   perf_drop_cnt (responses discarded) and perf_stall_cnt (cycles with pc_stall|if_id_stall),
//   32-bit wrapping counters, reset to 0.
module fetch_stage #(
  parameter int unsigned     XLEN     = fetch_stage_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = fetch_stage_pkg::NOP_INST
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pc_from_taken,
  input  logic               pc_stall,
  input  logic               if_id_stall,
  input  logic               if_id_flush,
  input  logic [XLEN-1:0]    ex_mem_pc_target,
  fetch_stage_if.master      imem,
  output logic               if_id_valid,
  output logic [XLEN-1:0]    if_id_pc,
  output logic [31:0]        if_id_inst
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_drop_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  import fetch_stage_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q;
  logic            drop_q, drop_d;

  logic            fire;
  logic            buf_load, buf_clear, buf_valid;
  logic [XLEN-1:0] buf_pc;
  logic [31:0]     buf_inst;
  logic            deliver_live, deliver_buf;

  logic            if_id_valid_q, if_id_valid_d;
  logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
  logic [31:0]     if_id_inst_q, if_id_inst_d;

  // A new request may only go out when nothing is outstanding, or when the outstanding one is
  // being consumed this cycle; no request is driven while reset is asserted.
  assign imem.req  = rst_n & ~pc_stall & ~pc_from_taken &
                     ((state_q == StIdle) |
                      ((state_q == StWait) & imem.rvalid & ~if_id_stall));
  assign imem.addr = pc_q;
  assign fire      = imem.req & imem.gnt;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    buf_load     = 1'b0;
    buf_clear    = 1'b0;
    deliver_live = 1'b0;
    deliver_buf  = 1'b0;

    if (fire) pc_d = pc_q + XLEN'(4);
    if (pc_from_taken) pc_d = ex_mem_pc_target;

    unique case (state_q)
      StIdle: begin
        if (fire) state_d = StWait;
      end
      StWait: begin
        if (imem.rvalid) begin
          if (pc_from_taken) begin
            // Response belongs to the wrong path; it is the only one outstanding.
            drop_d  = 1'b0;
            state_d = StIdle;
          end else if (drop_q) begin
            drop_d  = 1'b0;
            state_d = fire ? StWait : StIdle;
          end else if (if_id_stall) begin
            buf_load = 1'b1;
            state_d  = StHold;
          end else begin
            deliver_live = ~if_id_flush;
            state_d      = fire ? StWait : StIdle;
          end
        end else if (pc_from_taken) begin
          // Request still in flight: its response must be discarded when it lands.
          drop_d = 1'b1;
        end
      end
      StHold: begin
        if (pc_from_taken) begin
          buf_clear = 1'b1;
          state_d   = StIdle;
        end else if (!if_id_stall) begin
          buf_clear   = 1'b1;
          deliver_buf = buf_valid & ~if_id_flush;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // IF/ID next value: redirect/flush bubble > stall hold > parked buffer > live response > bubble.
  always_comb begin
    if_id_valid_d = 1'b0;
    if_id_pc_d    = '0;
    if_id_inst_d  = NOP_INST;
    if (!(if_id_flush | pc_from_taken)) begin
      if (if_id_stall) begin
        if_id_valid_d = if_id_valid_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_inst_d  = if_id_inst_q;
      end else if (deliver_buf) begin
        if_id_valid_d = 1'b1;
        if_id_pc_d    = buf_pc;
        if_id_inst_d  = buf_inst;
      end else if (deliver_live) begin
        if_id_valid_d = 1'b1;
        if_id_pc_d    = req_pc_q;
        if_id_inst_d  = imem.rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      req_pc_q      <= '0;
      drop_q        <= 1'b0;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= '0;
      if_id_inst_q  <= NOP_INST;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drop_q        <= drop_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_inst_q  <= if_id_inst_d;
      if (fire) req_pc_q <= pc_q;
    end
  end

  fetch_stage_resp_buf #(
    .XLEN     (XLEN),
    .NOP_INST (NOP_INST)
  ) u_resp_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (buf_load),
    .clear     (buf_clear),
    .load_pc   (req_pc_q),
    .load_inst (imem.rdata),
    .valid     (buf_valid),
    .pc        (buf_pc),
    .inst      (buf_inst)
  );

  assign if_id_valid = if_id_valid_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_inst  = if_id_inst_q;

`ifdef FETCH_PERF_EN
  logic        discard;
  logic [31:0] fetch_cnt_q, drop_cnt_q, stall_cnt_q;

  // Discarded: a stale or wrong-path live response, or a parked response killed by a redirect.
  assign discard = ((state_q == StWait) & imem.rvalid & (pc_from_taken | drop_q)) |
                   ((state_q == StHold) & pc_from_taken);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (deliver_buf | deliver_live) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (discard)                    drop_cnt_q  <= drop_cnt_q + 32'd1;
      if (pc_stall | if_id_stall)     stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_drop_cnt  = drop_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_from_taken = 1'b0;
  logic        pc_stall = 1'b0;
  logic        if_id_stall = 1'b0;
  logic        if_id_flush = 1'b0;
  logic [31:0] ex_mem_pc_target = '0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_drop_cnt, perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_stage_if #(.XLEN(32)) imem ();

  fetch_stage #(
    .XLEN     (32),
    .RESET_PC (32'h0),
    .NOP_INST (NOP)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_from_taken    (pc_from_taken),
    .pc_stall         (pc_stall),
    .if_id_stall      (if_id_stall),
    .if_id_flush      (if_id_flush),
    .ex_mem_pc_target (ex_mem_pc_target),
    .imem             (imem),
    .if_id_valid      (if_id_valid),
    .if_id_pc         (if_id_pc),
    .if_id_inst       (if_id_inst)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt   (perf_fetch_cnt),
    .perf_drop_cnt    (perf_drop_cnt),
    .perf_stall_cnt   (perf_stall_cnt)
`endif
  );

  // Instruction memory model: always grants, answers in order after imem_lat cycles.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  int          imem_lat = 1;
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_pend;

  assign imem.gnt = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_busy    <= 1'b0;
      mem_cnt     <= 0;
      mem_pend    <= '0;
      imem.rvalid <= 1'b0;
      imem.rdata  <= '0;
    end else begin
      imem.rvalid <= 1'b0;
      if (mem_busy) begin
        if (mem_cnt == 1) begin
          imem.rvalid <= 1'b1;
          imem.rdata  <= inst_of(mem_pend);
          mem_busy    <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end
      if (imem.req && imem.gnt) begin
        if (imem_lat == 1) begin
          imem.rvalid <= 1'b1;
          imem.rdata  <= inst_of(imem.addr);
        end else begin
          mem_busy <= 1'b1;
          mem_cnt  <= imem_lat - 1;
          mem_pend <= imem.addr;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Asserts reset mid-cycle (asynchronous), checks reset outputs, releases on a negedge.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    pc_from_taken = 1'b0;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_rst_valid"}, {31'b0, if_id_valid}, 32'h0);
    check({tag, "_rst_pc"}, if_id_pc, 32'h0);
    check({tag, "_rst_inst"}, if_id_inst, NOP);
    check({tag, "_rst_req"}, {31'b0, imem.req}, 32'h0);
    check({tag, "_rst_addr"}, imem.addr, 32'h0);
`ifdef FETCH_PERF_EN
    check({tag, "_rst_perf_fetch"}, perf_fetch_cnt, 32'h0);
    check({tag, "_rst_perf_drop"}, perf_drop_cnt, 32'h0);
    check({tag, "_rst_perf_stall"}, perf_stall_cnt, 32'h0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic        rec_en = 1'b0;
  logic [31:0] got_q[$];

  // One clock; records every delivery into IF/ID while recording is enabled. Ends on a negedge.
  task automatic step();
    @(posedge clk);
    #1;
    if (rec_en && if_id_valid) got_q.push_back(if_id_pc);
    @(negedge clk);
  endtask

  typedef struct packed {
    logic        taken;
    logic        pstall;
    logic        istall;
    logic        flush;
    logic [31:0] target;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[22];

  initial begin
    // Latency-1 imem. Each row: inputs applied for one cycle, IF/ID and PC checked after the edge.
    //            tk  ps  is  fl  target        v   IF_ID_pc      imem_addr
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h4};
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0,        32'h8};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,32'h4,        32'hC};
    vecs[3]  = '{1'b0,1'b0,1'b1,1'b0,32'h0,        1'b1,32'h4,        32'hC};   // 0x8 parked
    vecs[4]  = '{1'b0,1'b0,1'b1,1'b0,32'h0,        1'b1,32'h4,        32'hC};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,32'h8,        32'hC};   // buffer out
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h10};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,32'hC,        32'h14};
    vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,        1'b1,32'h10,       32'h14};  // pc_stall
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h18};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,32'h14,       32'h1C};
    vecs[11] = '{1'b0,1'b0,1'b1,1'b0,32'h0,        1'b1,32'h14,       32'h1C};  // 0x18 parked
    vecs[12] = '{1'b1,1'b0,1'b1,1'b0,32'h100,      1'b0,32'h0,        32'h100}; // redirect+stall
    vecs[13] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h104};
    vecs[14] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,32'h100,      32'h108};
    vecs[15] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,32'h104,      32'h10C};
    vecs[16] = '{1'b0,1'b0,1'b0,1'b1,32'h0,        1'b0,32'h0,        32'h110}; // flush
    vecs[17] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,32'h10C,      32'h114};
    vecs[18] = '{1'b1,1'b0,1'b0,1'b0,32'hFFFF_FFFC,1'b0,32'h0,        32'hFFFF_FFFC};
    vecs[19] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0};   // PC wraps
    vecs[20] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,32'hFFFF_FFFC,32'h4};
    vecs[21] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0,        32'h8};

    // Table-driven run.
    imem_lat = 1;
    apply_reset("tbl");
    for (int i = 0; i < 22; i++) begin
      pc_from_taken    = vecs[i].taken;
      pc_stall         = vecs[i].pstall;
      if_id_stall      = vecs[i].istall;
      if_id_flush      = vecs[i].flush;
      ex_mem_pc_target = vecs[i].target;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), {31'b0, if_id_valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_pc", i), if_id_pc, vecs[i].exp_pc);
        check($sformatf("vec%0d_inst", i), if_id_inst, inst_of(vecs[i].exp_pc));
      end else begin
        check($sformatf("vec%0d_inst", i), if_id_inst, NOP);
      end
      check($sformatf("vec%0d_addr", i), imem.addr, vecs[i].exp_addr);
      @(negedge clk);
    end
    pc_from_taken = 1'b0;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;

    // Latency-3 imem: redirect to 0x100 while the request for 0x10 is outstanding.
    begin
      logic        fired;
      logic [31:0] exp_seq[6];
      exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h104};
      imem_lat = 3;
      apply_reset("lat3");
      got_q.delete();
      rec_en = 1'b1;
      fired  = 1'b0;
      for (int i = 0; i < 40 && !fired; i++) begin
        fired = imem.req && (imem.addr == 32'h10);
        step();
      end
      check("lat3_fire_0x10", {31'b0, fired}, 32'h1);
      pc_from_taken    = 1'b1;
      ex_mem_pc_target = 32'h100;
      step();
      pc_from_taken = 1'b0;
      check("lat3_redirect_addr", imem.addr, 32'h100);
      for (int i = 0; i < 40; i++) step();
      rec_en = 1'b0;
      check("lat3_count", (got_q.size() >= 6) ? 32'h1 : 32'h0, 32'h1);
      for (int i = 0; i < 6; i++) begin
        check($sformatf("lat3_seq%0d", i), (i < got_q.size()) ? got_q[i] : 32'hDEAD_DEAD,
              exp_seq[i]);
      end
    end

`ifdef FETCH_PERF_EN
    // 10 deliveries, one wrong-path response discarded, three pc_stall cycles.
    imem_lat = 1;
    apply_reset("perf");
    for (int c = 1; c <= 16; c++) begin
      pc_from_taken    = (c == 5);
      ex_mem_pc_target = 32'h40;
      pc_stall         = (c >= 8 && c <= 10);
      step();
    end
    pc_from_taken = 1'b0;
    pc_stall      = 1'b0;
    check("perf_fetch", perf_fetch_cnt, 32'd10);
    check("perf_drop", perf_drop_cnt, 32'd1);
    check("perf_stall", perf_stall_cnt, 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
